data_cache_ctrl: RTL and testbench
==================================

Name: data_cache_ctrl

Overview:
- Parametrised, direct-mapped, write-back data cache between the CPU load/store port and block-wide data memory.
- Successor to the fixed 8-bit word-wide CPU–memory pairing. Generalises address/data width, block size and line count.
- Adds hit/miss handling, dirty write-back and block refill, all behind the existing BUSYWAIT stall handshake.

Parameters:
ADDR_W, 8, CPU byte-address width
DATA_W, 8, CPU word width
WORDS_PER_BLOCK, 4, words per line (power of 2, ≥2)
NUM_LINES, 8, cache lines (power of 2, ≥2)

Ports:
CLK  in  1  clock, rising-edge
RESET  in  1  asynchronous, active-low reset
READ  in  1  CPU load request
WRITE  in  1  CPU store request
ADDRESS  in  ADDR_W  CPU word address
WRITEDATA  in  DATA_W  CPU store data
READDATA  out  DATA_W  CPU load data
BUSYWAIT  out  1  CPU stall
MEM_READ  out  1  memory block read request
MEM_WRITE  out  1  memory block write request
MEM_ADDRESS  out  ADDR_W-log2(WORDS_PER_BLOCK)  memory block address {tag,index}
MEM_WRITEDATA  out  DATA_W*WORDS_PER_BLOCK  evicted block; word 0 in LSBs
MEM_READDATA  in  DATA_W*WORDS_PER_BLOCK  refill block; word 0 in LSBs
MEM_BUSYWAIT  in  1  memory busy; request done on the first cycle it is low while requested

Behaviour:
- Address split: OFF = log2(WORDS_PER_BLOCK) LSBs, then IDX = log2(NUM_LINES) bits, TAG = remaining MSBs. Defaults: 2/3/3.
- Per line storage: valid, dirty, tag, and WORDS_PER_BLOCK data words.
- Request = READ|WRITE. READ and WRITE together is treated as WRITE.
- hit = valid[IDX] && tag[IDX]==TAG, combinational.
- BUSYWAIT = request && !(state==IDLE && hit). With no request, BUSYWAIT=0.
- Read hit: READDATA = word[IDX][OFF] combinationally in the same cycle; zero-cycle stall.
- Write hit: word written and dirty[IDX] set at the next rising CLK; BUSYWAIT stays 0.
- READDATA is 0 when no READ hit is presented.
- States are IDLE, WRITEBACK, ALLOCATE, UPDATE.
- IDLE:
  - request && !hit && dirty[IDX] → WRITEBACK.
  - request && !hit && !dirty[IDX] → ALLOCATE.
  - Otherwise stay in IDLE.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={tag[IDX],IDX}, MEM_WRITEDATA=line[IDX].
  - On MEM_BUSYWAIT==0 → ALLOCATE.
- ALLOCATE:
  - MEM_READ=1, MEM_ADDRESS={TAG,IDX}.
  - On MEM_BUSYWAIT==0, latch MEM_READDATA → UPDATE.
- UPDATE (1 cycle):
  - Write the line, tag=TAG, valid=1, dirty=0 → IDLE.
  - The request now hits in IDLE; a store completes there.
- Memory outputs are 0 outside WRITEBACK/ALLOCATE. MEM_READ and MEM_WRITE are never both 1.
- The CPU must hold ADDRESS/WRITEDATA/READ/WRITE stable while BUSYWAIT=1. If the request drops mid-miss, the FSM still finishes the current transfer and returns to IDLE.
- Miss latency, clean line: memory read cycles + 1 UPDATE cycle + the hit cycle. Dirty line adds the write-back cycles.
- Reset (RESET=0, any time, asynchronous):
  - All valid and dirty bits cleared; state=IDLE.
  - All outputs 0, including mid-WRITEBACK/ALLOCATE, where the memory request is aborted immediately.
  - Data/tag arrays need not be cleared.
- Index wrap-around: addresses differing only in TAG map to the same line and evict each other.

Test Plan:
- Reset then READ ADDRESS=8'h05 → BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h01. Memory returns 32'hDDCCBBAA after 5 busy cycles → one UPDATE cycle, then READDATA=8'hBB with BUSYWAIT=0.
- Following READ 8'h07 → same-cycle hit, READDATA=8'hDD, no MEM_READ.
- WRITE 8'h06, WRITEDATA=8'h11 (hit) → BUSYWAIT=0. Next READ 8'h06 returns 8'h11; dirty[1]=1.
- READ 8'h25 (same index 1, tag 1) → WRITEBACK first: MEM_WRITE=1, MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDD11BBAA. Then ALLOCATE with MEM_ADDRESS=6'h09, then a hit.
- Assert RESET=0 mid-ALLOCATE → MEM_READ, BUSYWAIT and READDATA drop the same instant. After release, READ 8'h07 misses again.
- READ=WRITE=1 on a hit → behaves as a store; dirty bit set; READDATA=0.

Source files
------------

// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-back data cache with dirty write-back and block refill
module data_cache_ctrl #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_LINES       = 8
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic                                      READ,
    input  logic                                      WRITE,
    input  logic [ADDR_W-1:0]                         ADDRESS,
    input  logic [DATA_W-1:0]                         WRITEDATA,
    output logic [DATA_W-1:0]                         READDATA,
    output logic                                      BUSYWAIT,
    output logic                                      MEM_READ,
    output logic                                      MEM_WRITE,
    output logic [ADDR_W-$clog2(WORDS_PER_BLOCK)-1:0] MEM_ADDRESS,
    output logic [DATA_W*WORDS_PER_BLOCK-1:0]         MEM_WRITEDATA,
    input  logic [DATA_W*WORDS_PER_BLOCK-1:0]         MEM_READDATA,
    input  logic                                      MEM_BUSYWAIT
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
    state_t                     state_q, state_d;
    logic [NUM_LINES-1:0]       valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]           tag_q [NUM_LINES];
    logic [DATA_W-1:0]          data_q [NUM_LINES][WORDS_PER_BLOCK];
    logic [DATA_W*WORDS_PER_BLOCK-1:0] fill_q;
    logic [TAG_W-1:0]           mtag_q;
    logic [IDX_W-1:0]           midx_q;
    logic [OFF_W-1:0]           off;
    logic [IDX_W-1:0]           idx;
    logic [TAG_W-1:0]           tag;
    logic                       req, idle, hit, wr_hit, miss;
    assign off    = ADDRESS[OFF_W-1:0];
    assign idx    = ADDRESS[OFF_W +: IDX_W];
    assign tag    = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req    = READ | WRITE;
    assign idle   = state_q == IDLE;
    assign hit    = valid_q[idx] && tag_q[idx] == tag;
    assign wr_hit = idle && hit && WRITE;
    assign miss   = idle && req && !hit;
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        BUSYWAIT      = RESET && req && !(idle && hit);
        READDATA      = (RESET && idle && hit && READ && !WRITE) ? data_q[idx][off] : '0;
        MEM_WRITE     = state_q == WRITEBACK;
        MEM_READ      = state_q == ALLOCATE;
        MEM_ADDRESS   = MEM_WRITE ? {tag_q[midx_q], midx_q} : MEM_READ ? {mtag_q, midx_q} : '0;
        MEM_WRITEDATA = '0;
        for (int w = 0; w < WORDS_PER_BLOCK; w++)
            if (MEM_WRITE) MEM_WRITEDATA[w*DATA_W +: DATA_W] = data_q[midx_q][w];
        case (state_q)
            IDLE: begin
                if (miss) state_d = dirty_q[idx] ? WRITEBACK : ALLOCATE;
                if (wr_hit) dirty_d[idx] = 1'b1;
            end
            WRITEBACK: if (!MEM_BUSYWAIT) state_d = ALLOCATE;
            ALLOCATE:  if (!MEM_BUSYWAIT) state_d = UPDATE;
            UPDATE: begin
                state_d         = IDLE;
                valid_d[midx_q] = 1'b1;
                dirty_d[midx_q] = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end
    // Miss line is latched so a request dropped mid-miss still completes coherently
    always_ff @(posedge CLK) begin
        if (miss) begin
            mtag_q <= tag;
            midx_q <= idx;
        end
        if (state_q == ALLOCATE && !MEM_BUSYWAIT) fill_q <= MEM_READDATA;
        if (state_q == UPDATE) begin
            tag_q[midx_q] <= mtag_q;
            for (int w = 0; w < WORDS_PER_BLOCK; w++)
                data_q[midx_q][w] <= fill_q[w*DATA_W +: DATA_W];
        end else if (wr_hit) begin
            data_q[idx][off] <= WRITEDATA;
        end
    end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// tb_data_cache_ctrl: directed plan plus random traffic checked against a line/memory-level cache model
module tb_data_cache_ctrl;
    localparam int P_IDLE = 0, P_WB = 1, P_AL = 2, P_UP = 3;
    logic clk = 0, rst_n = 1, rd = 0, wr = 0, mbusy = 1;
    logic [7:0] addr = 0, wdata = 0, rdata;
    logic busy, mrd, mwr;
    logic [5:0] maddr;
    logic [31:0] mwdata, mrdata = 0;
    int vectors = 0, miscompares = 0;
    bit m_valid [8], m_dirty [8];
    logic [2:0] m_tag [8];
    logic [7:0] m_data [8][4];
    logic [31:0] mem [64];
    int ph = P_IDLE;
    logic [2:0] mtag = 0, midx = 0;
    logic [31:0] fill = 0;
    bit e_busy = 0;

    data_cache_ctrl dut (
        .CLK(clk), .RESET(rst_n), .READ(rd), .WRITE(wr), .ADDRESS(addr), .WRITEDATA(wdata),
        .READDATA(rdata), .BUSYWAIT(busy), .MEM_READ(mrd), .MEM_WRITE(mwr),
        .MEM_ADDRESS(maddr), .MEM_WRITEDATA(mwdata), .MEM_READDATA(mrdata), .MEM_BUSYWAIT(mbusy)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] line_of(input logic [2:0] i);
        return {m_data[i][3], m_data[i][2], m_data[i][1], m_data[i][0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        ph = P_IDLE;
        e_busy = 0;
    endtask

    // One clock: apply inputs, check every output against the model, then advance the model
    task automatic step(input logic r, input logic w, input logic [7:0] a, input logic [7:0] wd, input logic mb);
        logic [2:0] t, i;
        logic [1:0] o;
        bit h, rq;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = wd; mbusy = mb;
        mrdata = (ph == P_AL) ? mem[{mtag, midx}] : $urandom;
        #1;
        t = a[7:5]; i = a[4:2]; o = a[1:0];
        h = m_valid[i] && m_tag[i] == t;
        rq = r | w;
        e_busy = rq && !(ph == P_IDLE && h);
        chk("BUSYWAIT", {31'd0, busy}, {31'd0, e_busy});
        chk("READDATA", {24'd0, rdata}, (ph == P_IDLE && h && r && !w) ? {24'd0, m_data[i][o]} : 32'd0);
        chk("MEM_WRITE", {31'd0, mwr}, {31'd0, ph == P_WB});
        chk("MEM_READ", {31'd0, mrd}, {31'd0, ph == P_AL});
        chk("MEM_ADDRESS", {26'd0, maddr},
            ph == P_WB ? {26'd0, m_tag[midx], midx} : ph == P_AL ? {26'd0, mtag, midx} : 32'd0);
        chk("MEM_WRITEDATA", mwdata, ph == P_WB ? line_of(midx) : 32'd0);
        case (ph)
            P_IDLE: begin
                if (rq && h && w) begin
                    m_data[i][o] = wd;
                    m_dirty[i] = 1;
                end else if (rq && !h) begin
                    midx = i;
                    mtag = t;
                    ph = m_dirty[i] ? P_WB : P_AL;
                end
            end
            P_WB: if (!mb) begin
                mem[{m_tag[midx], midx}] = line_of(midx);
                ph = P_AL;
            end
            P_AL: if (!mb) begin
                fill = mrdata;
                ph = P_UP;
            end
            default: begin
                for (int k = 0; k < 4; k++) m_data[midx][k] = fill[k*8 +: 8];
                m_tag[midx] = mtag;
                m_valid[midx] = 1;
                m_dirty[midx] = 0;
                ph = P_IDLE;
            end
        endcase
    endtask

    task automatic serve();
        int n = 0;
        do begin
            step(rd, wr, addr, wdata, $urandom_range(0, 2) != 0);
            n++;
        end while (e_busy && n < 100);
        chk("serve_timeout", {31'd0, e_busy}, 32'd0);
    endtask

    initial begin
        bit dropped = 0;
        logic r = 0, w = 0;
        logic [7:0] a = 0, d = 0;
        int k;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) m_tag[i] = 0;
        mem[1] = 32'hDDCCBBAA;
        model_reset();
        #1 rst_n = 0; rd = 1; addr = 8'h05;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_read", {31'd0, mrd}, 32'd0);
        chk("rst_readdata", {24'd0, rdata}, 32'd0);
        rd = 0;
        @(negedge clk) rst_n = 1;
        // Clean miss with five busy memory cycles
        step(1, 0, 8'h05, 0, 1);
        chk("miss_busy", {31'd0, busy}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            step(1, 0, 8'h05, 0, 1);
            if (c == 0) begin
                chk("alloc_mem_read", {31'd0, mrd}, 32'd1);
                chk("alloc_addr", {26'd0, maddr}, 32'h01);
            end
        end
        step(1, 0, 8'h05, 0, 0);
        step(1, 0, 8'h05, 0, 1);
        chk("update_busy", {31'd0, busy}, 32'd1);
        step(1, 0, 8'h05, 0, 1);
        chk("refill_hit", {24'd0, rdata}, 32'hBB);
        chk("refill_busy", {31'd0, busy}, 32'd0);
        step(1, 0, 8'h07, 0, 1);
        chk("hit_word3", {24'd0, rdata}, 32'hDD);
        chk("hit_no_memread", {31'd0, mrd}, 32'd0);
        step(0, 1, 8'h06, 8'h11, 1);
        chk("write_hit_busy", {31'd0, busy}, 32'd0);
        step(1, 0, 8'h06, 0, 1);
        chk("read_after_write", {24'd0, rdata}, 32'h11);
        // Dirty eviction via same index, different tag
        step(1, 0, 8'h25, 0, 1);
        step(1, 0, 8'h25, 0, 1);
        chk("wb_mem_write", {31'd0, mwr}, 32'd1);
        chk("wb_addr", {26'd0, maddr}, 32'h01);
        chk("wb_data", mwdata, 32'hDD11BBAA);
        step(1, 0, 8'h25, 0, 0);
        step(1, 0, 8'h25, 0, 0);
        chk("wb_then_alloc", {31'd0, mrd}, 32'd1);
        chk("wb_alloc_addr", {26'd0, maddr}, 32'h09);
        step(1, 0, 8'h25, 0, 1);
        step(1, 0, 8'h25, 0, 1);
        chk("wb_refill_busy", {31'd0, busy}, 32'd0);
        chk("wb_refill_data", {24'd0, rdata}, {24'd0, mem[9][15:8]});
        // Asynchronous reset in the middle of an allocate
        step(1, 0, 8'h45, 0, 1);
        step(1, 0, 8'h45, 0, 1);
        chk("pre_reset_mem_read", {31'd0, mrd}, 32'd1);
        rst_n = 0;
        #1;
        chk("reset_mem_read", {31'd0, mrd}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_readdata", {24'd0, rdata}, 32'd0);
        rd = 0;
        model_reset();
        #1 rst_n = 1;
        step(1, 0, 8'h07, 0, 1);
        chk("post_reset_miss", {31'd0, busy}, 32'd1);
        serve();
        chk("post_reset_refill", {24'd0, rdata}, 32'hDD);
        // READ and WRITE together behave as a store
        step(1, 1, 8'h07, 8'h5A, 1);
        chk("rw_readdata", {24'd0, rdata}, 32'd0);
        chk("rw_busy", {31'd0, busy}, 32'd0);
        step(1, 0, 8'h07, 0, 1);
        chk("rw_stored", {24'd0, rdata}, 32'h5A);
        step(1, 0, 8'h27, 0, 1);
        step(1, 0, 8'h27, 0, 1);
        chk("rw_dirty_wb", {31'd0, mwr}, 32'd1);
        chk("rw_wb_word", {24'd0, mwdata[31:24]}, 32'h5A);
        serve();
        // Random traffic over three tags so lines hit, conflict and get evicted
        for (int c = 0; c < 3000; c++) begin
            if (dropped && ph != P_IDLE) begin
                r = 0; w = 0;
            end else if (e_busy) begin
                if ($urandom_range(0, 19) == 0) begin
                    r = 0; w = 0; dropped = 1;
                end
            end else begin
                dropped = 0;
                k = $urandom_range(0, 7);
                r = (k < 4) || (k == 6);
                w = (k == 4) || (k == 5) || (k == 6);
                a = {3'($urandom_range(0, 2)), 3'($urandom), 2'($urandom)};
                d = 8'($urandom);
            end
            step(r, w, a, d, $urandom_range(0, 2) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
